// File: rtl/ssd1306_spi_tx_pkg.sv
// Shared types and constants for the SSD1306 SPI transmitter.
package ssd1306_tx_pkg;

    typedef enum logic [2:0] {
        ST_RST_LOW  = 3'd0,
        ST_RST_WAIT = 3'd1,
        ST_IDLE     = 3'd2,
        ST_SETUP    = 3'd3,
        ST_SHIFT    = 3'd4,
        ST_HOLD     = 3'd5,
        ST_GAP      = 3'd6
    } tx_state_e;

    localparam int ENTRY_W = 9;

    typedef struct packed {
        logic       dc;
        logic [7:0] dat;
    } tx_entry_t;

    localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;
    localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;
    localparam logic [7:0] CMD_SET_COL     = 8'h21;
    localparam logic [7:0] CMD_SET_PAGE    = 8'h22;
    localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ssd1306_spi_tx_if.sv
// Core-side byte port of the SSD1306 transmitter; names follow the DUT's view.
interface ssd1306_spi_tx_if;
    logic [7:0] dat_i;
    logic       dc_i;
    logic       wr_i;
    logic       oled_rst_req_i;
    logic       full_o;
    logic       empty_o;
    logic       busy_o;
    logic       ovf_o;

    modport master (
        output dat_i, dc_i, wr_i, oled_rst_req_i,
        input  full_o, empty_o, busy_o, ovf_o
    );

    modport slave (
        input  dat_i, dc_i, wr_i, oled_rst_req_i,
        output full_o, empty_o, busy_o, ovf_o
    );
endinterface

// File: rtl/ssd1306_spi_tx_fifo.sv
// Show-ahead FIFO of {dc, byte} entries with wrapping pointers one bit wider than the address.
module ssd1306_tx_fifo
    import ssd1306_tx_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      flush_i,
    input  logic      wr_i,
    input  tx_entry_t wdata_i,
    input  logic      rd_i,
    output tx_entry_t rdata_o,
    output logic      full_o,
    output logic      empty_o
);
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    tx_entry_t   mem_q [2**AW];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance; a write while full or a read while empty is ignored.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_i && !full_o)  wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_i && !empty_o) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; flush empties the FIFO without touching storage.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i) begin
        if (wr_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/ssd1306_spi_tx.sv
// SPI mode-0 transmitter for an SSD1306 OLED: buffers bytes, sequences the
// panel reset and frames bytes with SS/DC.
//
// state     | meaning
// RST_LOW   | panel reset pin held low
// RST_WAIT  | reset released, panel settling
// IDLE      | waiting for a queued byte
// SETUP     | SS low, first bit on MOSI, before first SCK rise
// SHIFT     | clocking bits; back-to-back bytes chain here
// HOLD      | SCK low, SS still low after last bit
// GAP       | SS high before the next frame may start
module ssd1306_spi_tx
    import ssd1306_tx_pkg::*;
#(
    parameter int CLK_DIV         = 4,
    parameter int FIFO_AW         = 4,
    parameter int RST_LOW_CYCLES  = 480,
    parameter int RST_WAIT_CYCLES = 4800
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ssd1306_spi_tx_if.slave   bus,
    output logic              ss_o,
    output logic              scl_o,
    output logic              mosi_o,
    output logic              dc_o,
    output logic              oled_rst_o
);
    localparam int CNT_MAX = max3(CLK_DIV, RST_LOW_CYCLES, RST_WAIT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             ss_q, ss_d;
    logic             scl_q, scl_d;
    logic             dc_q, dc_d;
    logic             orst_q, orst_d;
    logic             ovf_q, ovf_d;

    logic             pop;
    logic             half_done;
    logic             fifo_wr;
    logic             fifo_full, fifo_empty;
    tx_entry_t        head, wr_entry;

    // A write coinciding with a reset request is dropped, as is any write while full.
    assign fifo_wr  = bus.wr_i && !bus.oled_rst_req_i;
    assign wr_entry = {bus.dc_i, bus.dat_i};
    assign ovf_d    = ovf_q | (fifo_wr && fifo_full);

    ssd1306_tx_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (bus.oled_rst_req_i),
        .wr_i    (fifo_wr),
        .wdata_i (wr_entry),
        .rd_i    (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign half_done = (cnt_q == CNT_W'(CLK_DIV - 1));

    // Next-state logic; bit_q == 8 marks the final low half of a byte with nothing queued behind it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        ss_d    = ss_q;
        scl_d   = scl_q;
        dc_d    = dc_q;
        orst_d  = orst_q;
        pop     = 1'b0;
        if (bus.oled_rst_req_i) begin
            state_d = ST_RST_LOW;
            cnt_d   = '0;
            bit_d   = '0;
            sh_d    = '0;
            ss_d    = 1'b1;
            scl_d   = 1'b0;
            dc_d    = 1'b0;
            orst_d  = 1'b0;
        end else begin
            case (state_q)
                ST_RST_LOW: begin
                    if (cnt_q == CNT_W'(RST_LOW_CYCLES - 1)) begin
                        orst_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_RST_WAIT;
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
                ST_RST_WAIT: begin
                    if (cnt_q == CNT_W'(RST_WAIT_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        sh_d    = head.dat;
                        dc_d    = head.dc;
                        ss_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (half_done) begin
                        scl_d   = 1'b1;
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = ST_SHIFT;
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
                ST_SHIFT: begin
                    if (!half_done) cnt_d = cnt_q + CNT_W'(1);
                    else begin
                        cnt_d = '0;
                        if (scl_q) begin
                            scl_d = 1'b0;
                            if (bit_q == 4'd7) begin
                                if (!fifo_empty) begin
                                    pop   = 1'b1;
                                    sh_d  = head.dat;
                                    dc_d  = head.dc;
                                    bit_d = '0;
                                end else bit_d = 4'd8;
                            end else begin
                                sh_d  = {sh_q[6:0], 1'b0};
                                bit_d = bit_q + 4'd1;
                            end
                        end else if (bit_q == 4'd8) begin
                            state_d = ST_HOLD;
                        end else scl_d = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (half_done) begin
                        ss_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_GAP;
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
                ST_GAP: begin
                    if (half_done) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
                default: state_d = ST_RST_LOW;
            endcase
        end
    end

    // State and pin registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RST_LOW;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            ss_q    <= 1'b1;
            scl_q   <= 1'b0;
            dc_q    <= 1'b0;
            orst_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ss_q    <= ss_d;
            scl_q   <= scl_d;
            dc_q    <= dc_d;
            orst_q  <= orst_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ss_o        = ss_q;
    assign scl_o       = scl_q;
    assign mosi_o      = sh_q[7];
    assign dc_o        = dc_q;
    assign oled_rst_o  = orst_q;
    assign bus.full_o  = fifo_full;
    assign bus.empty_o = fifo_empty;
    assign bus.busy_o  = (state_q != ST_IDLE) || !fifo_empty;
    assign bus.ovf_o   = ovf_q;
endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// Self-checking bench: an SPI-slave monitor decodes the pin stream into
// {dc, byte} entries which are compared against the bytes written.
module tb_ssd1306_spi_tx;
    import ssd1306_tx_pkg::*;

    localparam int D     = 2;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int RLOW  = 8;
    localparam int RWAIT = 16;

    logic clk = 1'b0;
    logic rst;
    logic ss, scl, mosi, dc, orst;

    ssd1306_spi_tx_if bus();

    ssd1306_spi_tx #(
        .CLK_DIV(D), .FIFO_AW(AW), .RST_LOW_CYCLES(RLOW), .RST_WAIT_CYCLES(RWAIT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .ss_o(ss), .scl_o(scl), .mosi_o(mosi), .dc_o(dc), .oled_rst_o(orst)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // SPI slave monitor
    logic [8:0] rx_q [$];
    int   scl_rise = 0, ss_fall = 0, fall_cyc = 0, rise_cyc = 0;
    int   mosi_bad = 0, dc_bad = 0, nbits = 0;
    logic p_ss = 1'b1, p_scl = 1'b0, p_mosi = 1'b0, p_dc = 1'b0, bdc = 1'b0;
    logic [7:0] shv = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (p_ss && !ss) begin ss_fall++; fall_cyc = cyc; end
            if (!p_ss && ss) rise_cyc = cyc;
            if (!p_ss && !ss) begin
                if (mosi !== p_mosi && !(p_scl && !scl)) mosi_bad++;
                if (dc !== p_dc && !(p_scl && !scl)) dc_bad++;
            end
            if (ss) nbits = 0;
            if (!p_scl && scl) begin
                scl_rise++;
                if (!ss) begin
                    if (nbits == 0) bdc = dc;
                    shv = {shv[6:0], mosi};
                    nbits++;
                    if (nbits == 8) begin
                        rx_q.push_back({bdc, shv});
                        nbits = 0;
                    end
                end
            end
        end
        p_ss = ss; p_scl = scl; p_mosi = mosi; p_dc = dc;
    end

    logic [8:0] ents [8];

    task automatic wait_idle(input string tag, output int idle_cyc);
        int n = 0;
        @(negedge clk);
        while (bus.busy_o && n < 3000) begin @(negedge clk); n++; end
        idle_cyc = cyc;
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s idle timeout: busy=%0b required 0", tag, bus.busy_o);
        end
    endtask

    // Frame model: n queued bytes go out in one SS frame of (16n+2)*D cycles.
    task automatic run_burst(input int n, input string tag);
        int base, f0, r0, t0, idle_c;
        base = rx_q.size(); f0 = ss_fall; r0 = scl_rise;
        @(negedge clk);
        t0 = cyc;
        for (int i = 0; i < n; i++) begin
            bus.wr_i = 1'b1; bus.dc_i = ents[i][8]; bus.dat_i = ents[i][7:0];
            @(negedge clk);
        end
        bus.wr_i = 1'b0;
        wait_idle(tag, idle_c);
        checks++;
        if (fall_cyc - t0 !== 2) begin errors++;
            $display("FAIL %s ss latency: got %0d required 2", tag, fall_cyc - t0); end
        checks++;
        if (rise_cyc - fall_cyc !== (16 * n + 2) * D) begin errors++;
            $display("FAIL %s ss low cycles: got %0d required %0d", tag, rise_cyc - fall_cyc, (16 * n + 2) * D); end
        checks++;
        if (idle_c - rise_cyc !== D) begin errors++;
            $display("FAIL %s busy drop: got %0d required %0d", tag, idle_c - rise_cyc, D); end
        checks++;
        if (ss_fall - f0 !== 1) begin errors++;
            $display("FAIL %s frames: got %0d required 1", tag, ss_fall - f0); end
        checks++;
        if (scl_rise - r0 !== 8 * n) begin errors++;
            $display("FAIL %s sck rises: got %0d required %0d", tag, scl_rise - r0, 8 * n); end
        checks++;
        if (rx_q.size() - base !== n) begin errors++;
            $display("FAIL %s rx count: got %0d required %0d", tag, rx_q.size() - base, n); end
        for (int i = 0; i < n && base + i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[base + i] !== ents[i]) begin errors++;
                $display("FAIL %s byte%0d: got %h required %h", tag, i, rx_q[base + i], ents[i]); end
        end
    endtask

    task automatic test_reset();
        logic exp_orst, exp_busy;
        rst = 1'b1;
        bus.wr_i = 1'b0; bus.dc_i = 1'b0; bus.dat_i = '0; bus.oled_rst_req_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ss, scl, mosi, dc, orst, bus.full_o, bus.empty_o, bus.busy_o, bus.ovf_o} !== 9'b100000110) begin
            errors++;
            $display("FAIL reset values: got %b required 100000110",
                     {ss, scl, mosi, dc, orst, bus.full_o, bus.empty_o, bus.busy_o, bus.ovf_o});
        end
        rst = 1'b0;
        for (int k = 1; k <= RLOW + RWAIT; k++) begin
            @(negedge clk);
            exp_orst = (k >= RLOW);
            exp_busy = (k < RLOW + RWAIT);
            checks++;
            if (orst !== exp_orst) begin errors++;
                $display("FAIL reset seq oled_rst k=%0d: got %b required %b", k, orst, exp_orst); end
            checks++;
            if ({ss, scl, mosi} !== 3'b100) begin errors++;
                $display("FAIL reset seq pins k=%0d: got %b required 100", k, {ss, scl, mosi}); end
            checks++;
            if (bus.busy_o !== exp_busy) begin errors++;
                $display("FAIL reset seq busy k=%0d: got %b required %b", k, bus.busy_o, exp_busy); end
        end
    endtask

    task automatic test_single_a5();
        ents[0] = {1'b0, 8'hA5};
        run_burst(1, "single_a5");
    endtask

    task automatic test_back_to_back();
        ents[0] = {1'b0, CMD_SET_COL};
        ents[1] = {1'b1, 8'hFF};
        run_burst(2, "back_to_back");
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) ents[i] = 9'($urandom);
            run_burst(n, "random");
        end
    endtask

    task automatic test_overflow();
        int base, f0, idle_c, t;
        logic [8:0] exp_q [$];
        base = rx_q.size(); f0 = ss_fall;
        @(negedge clk); bus.oled_rst_req_i = 1'b1;
        @(negedge clk); bus.oled_rst_req_i = 1'b0;
        t = 0;
        while (orst !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (bus.ovf_o !== 1'b0) begin errors++;
            $display("FAIL ovf before: got %b required 0", bus.ovf_o); end
        for (int i = 0; i < DEPTH + 1; i++) begin
            ents[i] = 9'($urandom);
            if (exp_q.size() < DEPTH) exp_q.push_back(ents[i]);
            bus.wr_i = 1'b1; bus.dc_i = ents[i][8]; bus.dat_i = ents[i][7:0];
            @(negedge clk);
        end
        bus.wr_i = 1'b0;
        checks++;
        if ({bus.full_o, bus.ovf_o, ss, orst} !== 4'b1111) begin errors++;
            $display("FAIL overflow flags full,ovf,ss,rst: got %b required 1111", {bus.full_o, bus.ovf_o, ss, orst}); end
        wait_idle("overflow", idle_c);
        checks++;
        if (rx_q.size() - base !== DEPTH) begin errors++;
            $display("FAIL overflow rx count: got %0d required %0d", rx_q.size() - base, DEPTH); end
        checks++;
        if (ss_fall - f0 !== 1) begin errors++;
            $display("FAIL overflow frames: got %0d required 1", ss_fall - f0); end
        for (int i = 0; i < DEPTH && base + i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[base + i] !== exp_q[i]) begin errors++;
                $display("FAIL overflow byte%0d: got %h required %h", i, rx_q[base + i], exp_q[i]); end
        end
    endtask

    task automatic test_abort();
        int base, r0, rises, t, idle_c;
        logic prev;
        base = rx_q.size(); r0 = scl_rise; rises = 0; prev = scl; t = 0;
        @(negedge clk);
        bus.wr_i = 1'b1; bus.dc_i = 1'b1; bus.dat_i = 8'($urandom);
        @(negedge clk);
        bus.wr_i = 1'b0;
        while (rises < 4 && t < 300) begin
            @(negedge clk);
            if (!prev && scl) rises++;
            prev = scl; t++;
        end
        checks++;
        if (rises !== 4) begin errors++;
            $display("FAIL abort wait: got %0d rises required 4", rises); end
        bus.oled_rst_req_i = 1'b1;
        @(negedge clk);
        bus.oled_rst_req_i = 1'b0;
        checks++;
        if ({ss, scl, orst, bus.empty_o} !== 4'b1001) begin errors++;
            $display("FAIL abort pins ss,scl,rst,empty: got %b required 1001", {ss, scl, orst, bus.empty_o}); end
        wait_idle("abort", idle_c);
        checks++;
        if (scl_rise - r0 !== 4) begin errors++;
            $display("FAIL abort sck rises: got %0d required 4", scl_rise - r0); end
        checks++;
        if (rx_q.size() - base !== 0) begin errors++;
            $display("FAIL abort rx count: got %0d required 0", rx_q.size() - base); end
    endtask

    task automatic test_wr_with_req();
        int base, r0, idle_c;
        logic ovf0;
        base = rx_q.size(); r0 = scl_rise; ovf0 = bus.ovf_o;
        @(negedge clk);
        bus.wr_i = 1'b1; bus.oled_rst_req_i = 1'b1; bus.dat_i = 8'($urandom); bus.dc_i = 1'b0;
        @(negedge clk);
        bus.wr_i = 1'b0; bus.oled_rst_req_i = 1'b0;
        checks++;
        if (bus.empty_o !== 1'b1) begin errors++;
            $display("FAIL wr_req empty: got %b required 1", bus.empty_o); end
        checks++;
        if (bus.ovf_o !== ovf0) begin errors++;
            $display("FAIL wr_req ovf: got %b required %b", bus.ovf_o, ovf0); end
        wait_idle("wr_req", idle_c);
        checks++;
        if (scl_rise - r0 !== 0 || rx_q.size() - base !== 0) begin errors++;
            $display("FAIL wr_req activity: got %0d rises %0d bytes required 0", scl_rise - r0, rx_q.size() - base); end
    endtask

    task automatic test_stream_rules();
        checks++;
        if (mosi_bad !== 0) begin errors++;
            $display("FAIL mosi off falling edge: got %0d required 0", mosi_bad); end
        checks++;
        if (dc_bad !== 0) begin errors++;
            $display("FAIL dc off falling edge: got %0d required 0", dc_bad); end
    endtask

    task automatic test_ovf_clear();
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.ovf_o, orst, ss, bus.empty_o, bus.busy_o} !== 5'b00111) begin errors++;
            $display("FAIL rst clears ovf,rst,ss,empty,busy: got %b required 00111",
                     {bus.ovf_o, orst, ss, bus.empty_o, bus.busy_o}); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_random();
        test_overflow();
        test_abort();
        test_wr_with_req();
        test_stream_rules();
        test_ovf_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ssd1306_spi_tx.md
# ssd1306_spi_tx

SPI-master transmitter that drives a physical SSD1306 OLED with command and data bytes. It is the opposite end of the SSD1306 link from the on-chip ssd1306 snooper/renderer, which consumes this same SPI stream. The block buffers bytes written by a core-side port, sequences the OLED hardware reset, and shifts bytes out in SPI mode 0 with chip-select and D/C framing. It sits between an IO-mapped register front end and the OLED_SS/OLED_DC/OLED_RST/SCK/MOSI pins.

## Interface
Parameters:
- CLK_DIV, 4: SCK half-period in clk_i cycles, ≥1 (48 MHz / 8 = 6 MHz SCK).
- FIFO_AW, 4: FIFO address width, giving a depth of 2^FIFO_AW entries of {dc, byte}.
- RST_LOW_CYCLES, 480: OLED reset-low duration (10 µs at 48 MHz).
- RST_WAIT_CYCLES, 4800: wait after reset release before the first byte.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset; one clock domain
- dat_i  in  8  byte to send
- dc_i  in  1  0 = command, 1 = data
- wr_i  in  1  push {dc_i, dat_i} when full_o = 0
- oled_rst_req_i  in  1  single-cycle pulse that restarts the OLED reset sequence
- full_o  out  1  FIFO full
- empty_o  out  1  FIFO empty
- busy_o  out  1  FSM not in IDLE, or FIFO not empty
- ovf_o  out  1  sticky; set by a write while full; cleared only by rst_i
- ss_o, scl_o, mosi_o, dc_o, oled_rst_o  out  1 each  pin drives; oled_rst_o is active-low

## Operation
- FSM states: RST_LOW, RST_WAIT, IDLE, SETUP, SHIFT, HOLD, GAP.
- On rst_i, or when oled_rst_req_i is high in any state: go to RST_LOW, flush the FIFO, abort any byte in flight, and drive ss_o=1, scl_o=0, mosi_o=0, dc_o=0, oled_rst_o=0.
- RST_LOW: count RST_LOW_CYCLES, then oled_rst_o=1 and go to RST_WAIT.
- RST_WAIT: count RST_WAIT_CYCLES, then go to IDLE.
- Writes are accepted in every state, including RST_LOW and RST_WAIT. Exception: a write in the same cycle as oled_rst_req_i is dropped.
- Write while full: the write is dropped and ovf_o is set. A pop in the same cycle does not make room for it.
- IDLE: when the FIFO is non-empty, pop the head, load the shift register, set dc_o, ss_o=0, mosi_o=bit7, and go to SETUP.
- SETUP: hold for CLK_DIV cycles, then go to SHIFT.
- SHIFT: 8 bits, MSB first. Each bit is SCK high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - mosi_o changes only on the SCK falling edge; the slave samples on the rising edge.
- End of the 8th bit (its falling edge):
  - FIFO non-empty: pop the next entry, load mosi_o=bit7 and the new dc_o on that same edge, keep ss_o=0, stay in SHIFT. No SETUP between back-to-back bytes.
  - FIFO empty: go to HOLD.
- HOLD: SCK low, ss_o low for CLK_DIV cycles. Then ss_o=1 and go to GAP.
- GAP: ss_o high for CLK_DIV cycles, then go to IDLE.
- Between bytes scl_o=0 (CPOL=0). dc_o holds its value until the next byte is loaded.

## Timing
- Reset values: ss_o=1, scl_o=0, mosi_o=0, dc_o=0, oled_rst_o=0, full_o=0, empty_o=1, busy_o=1, ovf_o=0.
- All outputs are registered.
- Latency from wr_i (FIFO empty, FSM in IDLE) to ss_o falling: 2 cycles (write cycle, then pop cycle).
- Single byte, with D = CLK_DIV: SETUP D + SHIFT 16·D + HOLD D + GAP D. ss_o is low for 18·D cycles.
- Back-to-back stream throughput: one byte per 16·D cycles.
- Half-period counter: 0..CLK_DIV−1. With CLK_DIV=1, SCK = clk_i/2.
- FIFO pointers are FIFO_AW+1 bits wide and wrap. full_o and empty_o are decoded from the MSB difference.

## Structure
- Package ssd1306_tx_pkg holds:
  - the state enum encoding;
  - FIFO entry width (9);
  - SSD1306 command constants (DISPLAY_OFF 8'hAE, DISPLAY_ON 8'hAF, SET_COL 8'h21, SET_PAGE 8'h22, CHARGE_PUMP 8'h8D) for firmware and test use.
- One sub-module: ssd1306_tx_fifo, a synchronous FIFO, 9 bits × 2^FIFO_AW, with show-ahead read and full/empty flags. The FSM and shifter live in the top.

## Test plan
- Apply rst_i with RST_LOW_CYCLES=8, RST_WAIT_CYCLES=16 → oled_rst_o low for exactly 8 cycles, then high; ss_o stays 1 through 16 wait cycles; all reset values hold.
- CLK_DIV=2, write 8'hA5 with dc=0 in IDLE → ss_o falls 2 cycles later; mosi_o sampled on 8 rising edges reads 1,0,1,0,0,1,0,1; ss_o is low for 36 cycles; busy_o then drops.
- Write 8'h21 (dc=0) then 8'hFF (dc=1) back-to-back → ss_o does not rise between the bytes; dc_o switches on the 8th falling edge; 16 SCK rising edges in total.
- FIFO_AW=2, hold in RST_WAIT and write 5 bytes → 4 accepted, full_o=1, ovf_o=1; all 4 bytes are sent after RST_WAIT in order.
- Pulse oled_rst_req_i during bit 4 of a byte → next cycle ss_o=1, scl_o=0, oled_rst_o=0, empty_o=1; the remaining bits are never emitted.
- Write and oled_rst_req_i in the same cycle → the write is dropped, empty_o=1, ovf_o unchanged.
